// File: rtl/conv_pkg.sv
// conv_pkg: shared encodings and tap constants for the convolution window generator.
package conv_pkg;
  typedef enum logic {MODE_3X3, MODE_PW} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;
  localparam int TAP_NUM = 9;
  localparam int CENTRE_TAP = 4;
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: two chained row delay lines sharing one pointer that wraps at the runtime width.
module conv_line_buffer #(
  parameter int WIDTH = 144,
  parameter int MAX_WIDTH = 320,
  parameter int DIM_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [DIM_WIDTH-1:0] i_width,
  input  logic [WIDTH-1:0]     i_din,
  output logic [WIDTH-1:0]     o_row1,
  output logic [WIDTH-1:0]     o_row2
);
  localparam int AW = $clog2(MAX_WIDTH);
  logic [WIDTH-1:0] r_mem1 [MAX_WIDTH];
  logic [WIDTH-1:0] r_mem2 [MAX_WIDTH];
  logic [AW-1:0] r_ptr;
  assign o_row1 = r_mem1[r_ptr];
  assign o_row2 = r_mem2[r_ptr];
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_ptr <= '0;
    else if (i_en) r_ptr <= (DIM_WIDTH'(r_ptr) == i_width - DIM_WIDTH'(1)) ? '0 : r_ptr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem1[r_ptr] <= i_din;
      r_mem2[r_ptr] <= r_mem1[r_ptr];
    end
  end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streams 3x3 zero-padded (or 1x1) windows from a raster pixel stream, optional stride 2.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int CH_NUM = 18,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH = 320,
  parameter int DIM_WIDTH = 9
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_start,
  input  logic                                 cfg_mode,
  input  logic                                 cfg_stride2,
  input  logic [DIM_WIDTH-1:0]                 cfg_width,
  input  logic [DIM_WIDTH-1:0]                 cfg_height,
  input  logic [CH_NUM*DATA_WIDTH-1:0]         in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [TAP_NUM*CH_NUM*DATA_WIDTH-1:0] out_window,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 cfg_err
);
  localparam int PW = CH_NUM * DATA_WIDTH;
  state_e r_state, w_next;
  mode_e r_mode;
  logic r_stride2, r_out_valid, r_frame_done, r_cfg_err;
  logic [DIM_WIDTH-1:0] r_width, r_height, r_col, r_row, r_ccol, r_crow, r_fcnt;
  logic [DIM_WIDTH-1:0] w_wm1, w_hm1, w_cr, w_cc;
  logic [PW-1:0] r_ca [3];
  logic [PW-1:0] r_cb [3];
  logic [PW-1:0] w_new [3];
  logic [PW-1:0] w_pix, w_lb1, w_lb2;
  logic [TAP_NUM*PW-1:0] r_out_window, w_win;
  logic w_can, w_acc, w_vbeat, w_beat, w_pw, w_primed, w_emit, w_cfg_ok, w_last_in;
  assign w_wm1 = r_width - DIM_WIDTH'(1);
  assign w_hm1 = r_height - DIM_WIDTH'(1);
  assign w_can = !r_out_valid || out_ready;
  assign in_ready = (r_state == S_RUN) && w_can;
  assign w_acc = in_valid && in_ready;
  assign w_vbeat = (r_state == S_FLUSH) && w_can;
  assign w_beat = w_acc || w_vbeat;
  assign w_pix = (r_state == S_FLUSH) ? '0 : in_data;
  assign w_pw = r_mode == MODE_PW;
  assign w_last_in = (r_row == w_hm1) && (r_col == w_wm1);
  assign w_cfg_ok = cfg_width >= DIM_WIDTH'(2) && cfg_width <= DIM_WIDTH'(MAX_WIDTH) && cfg_height >= DIM_WIDTH'(2);
  // 3x3 centre lags the input by W+1 stream positions
  assign w_primed = w_pw || r_state == S_FLUSH || r_row >= DIM_WIDTH'(2) || (r_row == DIM_WIDTH'(1) && r_col != '0);
  assign w_cr = w_pw ? r_row : r_crow;
  assign w_cc = w_pw ? r_col : r_ccol;
  assign w_emit = w_primed && (!r_stride2 || (!w_cr[0] && !w_cc[0]));
  assign w_new[0] = w_lb2;
  assign w_new[1] = w_lb1;
  assign w_new[2] = w_pix;
  assign out_window = r_out_window;
  assign out_valid = r_out_valid;
  assign busy = r_state != S_IDLE;
  assign frame_done = r_frame_done;
  assign cfg_err = r_cfg_err;
  conv_line_buffer #(.WIDTH(PW), .MAX_WIDTH(MAX_WIDTH), .DIM_WIDTH(DIM_WIDTH)) u_lb (
    .clk(clk), .rst(rst), .i_clr(cfg_start && r_state == S_IDLE && w_cfg_ok),
    .i_en(w_beat && !w_pw), .i_width(r_width), .i_din(w_pix), .o_row1(w_lb1), .o_row2(w_lb2)
  );
  // row wrap leaves stale columns in the shift register; the mask hides them
  always_comb begin
    w_win = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        if (!w_pw && !((y == 0 && w_cr == '0) || (y == 2 && w_cr == w_hm1) ||
                       (x == 0 && w_cc == '0) || (x == 2 && w_cc == w_wm1)))
          w_win[(3*y+x)*PW +: PW] = x == 0 ? r_ca[y] : x == 1 ? r_cb[y] : w_new[y];
    if (w_pw) w_win[CENTRE_TAP*PW +: PW] = w_pix;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (cfg_start && w_cfg_ok) ? S_RUN : S_IDLE;
      S_RUN:   w_next = (w_acc && w_last_in) ? (w_pw ? S_DONE : S_FLUSH) : S_RUN;
      S_FLUSH: w_next = (w_vbeat && r_fcnt == r_width) ? S_DONE : S_FLUSH;
      S_DONE:  w_next = w_can ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_beat && !w_pw) begin
      r_ca <= r_cb;
      r_cb <= w_new;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode <= MODE_3X3;
      r_stride2 <= 1'b0;
      r_width <= '0;
      r_height <= '0;
      r_col <= '0;
      r_row <= '0;
      r_ccol <= '0;
      r_crow <= '0;
      r_fcnt <= '0;
      r_out_valid <= 1'b0;
      r_out_window <= '0;
      r_frame_done <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_frame_done <= r_state == S_DONE && w_next == S_IDLE;
      if (cfg_start) begin
        if (r_state == S_IDLE && w_cfg_ok) begin
          r_mode <= mode_e'(cfg_mode);
          r_stride2 <= cfg_stride2;
          r_width <= cfg_width;
          r_height <= cfg_height;
          r_col <= '0;
          r_row <= '0;
          r_ccol <= '0;
          r_crow <= '0;
          r_fcnt <= '0;
          r_cfg_err <= 1'b0;
        end else r_cfg_err <= 1'b1;
      end
      if (w_acc) begin
        r_col <= (r_col == w_wm1) ? '0 : r_col + DIM_WIDTH'(1);
        if (r_col == w_wm1 && r_row != w_hm1) r_row <= r_row + DIM_WIDTH'(1);
      end
      if (w_vbeat) r_fcnt <= r_fcnt + DIM_WIDTH'(1);
      if (w_beat && w_primed && !w_pw) begin
        r_ccol <= (r_ccol == w_wm1) ? '0 : r_ccol + DIM_WIDTH'(1);
        if (r_ccol == w_wm1) r_crow <= r_crow + DIM_WIDTH'(1);
      end
      if (w_beat) begin
        r_out_valid <= w_emit;
        if (w_emit) r_out_window <= w_win;
      end else if (out_ready) r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed frames checked against a zero-padded window model.
module tb_conv_window_gen;
  import conv_pkg::*;
  localparam int CH = 2, DW = 8, MAXW = 320, DIMW = 9, PW = CH * DW, WW = TAP_NUM * PW;
  logic clk = 0, rst = 1, cfg_start = 0, cfg_mode = 0, cfg_stride2 = 0, in_valid = 0, out_ready = 0;
  logic [DIMW-1:0] cfg_width = '0, cfg_height = '0;
  logic [PW-1:0] in_data = '0;
  logic in_ready, out_valid, busy, frame_done, cfg_err;
  logic [WW-1:0] out_window;
  int checks = 0, errors = 0, ch_off = 0;
  always #5 clk = ~clk;
  conv_window_gen #(.CH_NUM(CH), .DATA_WIDTH(DW), .MAX_WIDTH(MAXW), .DIM_WIDTH(DIMW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_stride2(cfg_stride2),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_window(out_window), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );
  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [PW-1:0] pix(input int r, input int c);
    logic [PW-1:0] p;
    for (int k = 0; k < CH; k++) p[k*DW +: DW] = DW'(16 * r + c + ch_off * k);
    return p;
  endfunction
  function automatic logic [WW-1:0] exp_win(input int r, input int c, input int w, input int h, input bit pw);
    logic [WW-1:0] v;
    int rr, cc;
    v = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++) begin
        rr = r + y - 1;
        cc = c + x - 1;
        if (pw ? (y == 1 && x == 1) : (rr >= 0 && rr < h && cc >= 0 && cc < w))
          v[(3*y+x)*PW +: PW] = pix(rr, cc);
      end
    return v;
  endfunction
  task automatic start(input bit mode, input bit s2, input int w, input int h);
    cfg_mode = mode;
    cfg_stride2 = s2;
    cfg_width = DIMW'(w);
    cfg_height = DIMW'(h);
    cfg_start = 1;
    @(posedge clk);
    #1 cfg_start = 0;
  endtask
  task automatic run_frame(input bit mode, input bit s2, input int w, input int h, input int rdy,
                           input int vld, input int inj, input bit abort, output int nwin, output int ndone);
    int idx, er, ec, st, left;
    bit prev_acc;
    idx = 0; er = 0; ec = 0; st = s2 ? 2 : 1; left = -1; prev_acc = 0; nwin = 0; ndone = 0;
    start(mode, s2, w, h);
    chk("busy_start", busy, 1);
    for (int cyc = 0; cyc < w * h * 20 + 100; cyc++) begin
      out_ready = $urandom_range(99) < rdy;
      in_valid = idx < w * h && $urandom_range(99) < vld;
      in_data = in_valid ? pix(idx / w, idx % w) : '0;
      cfg_start = cyc == inj;
      if (cyc == inj) begin
        cfg_width = 3; cfg_height = 2; cfg_mode = 1; cfg_stride2 = 1;
      end
      rst = abort && idx == w * h;
      #1;
      if (mode && rdy == 100) chk("pw_latency", out_valid, prev_acc);
      if (out_valid) begin
        chk($sformatf("win_r%0d_c%0d", er, ec), out_window, exp_win(er, ec, w, h, mode));
        if (out_ready) begin
          nwin++;
          ec += st;
          if (ec >= w) begin ec = 0; er += st; end
        end
      end
      if (frame_done) ndone++;
      prev_acc = in_valid && in_ready;
      if (prev_acc) idx++;
      @(posedge clk);
      #1;
      if (rst) begin rst = 0; break; end
      if (ndone > 0 && left < 0) left = 4;
      if (left > 0) left--;
      if (left == 0) break;
    end
    cfg_start = 0;
    if (abort) chk("abort_in_flush", idx, w * h);
    else begin
      chk("frame_end", left, 0);
      chk("busy_end", busy, 0);
    end
  endtask
  initial begin
    int nwin, ndone;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_window", out_window, 0);
    rst = 0;
    run_frame(0, 0, 4, 4, 100, 100, -1, 0, nwin, ndone);
    chk("n_win_4x4", nwin, 16);
    chk("n_done_4x4", ndone, 1);
    run_frame(0, 1, 4, 4, 60, 80, -1, 0, nwin, ndone);
    chk("n_win_4x4_s2", nwin, 4);
    chk("n_done_4x4_s2", ndone, 1);
    run_frame(0, 1, 5, 3, 70, 70, -1, 0, nwin, ndone);
    chk("n_win_5x3_s2", nwin, 6);
    run_frame(1, 0, 3, 2, 100, 70, -1, 0, nwin, ndone);
    chk("n_win_pw", nwin, 6);
    chk("n_done_pw", ndone, 1);
    start(0, 0, 1, 4);
    #1;
    chk("err_w1", cfg_err, 1);
    chk("idle_w1", busy, 0);
    @(posedge clk);
    #1;
    start(0, 0, 321, 4);
    #1;
    chk("idle_wmax", busy, 0);
    @(posedge clk);
    #1;
    start(0, 0, 4, 1);
    #1;
    chk("idle_h1", busy, 0);
    @(posedge clk);
    #1;
    run_frame(0, 0, 4, 4, 100, 100, 5, 0, nwin, ndone);
    chk("n_win_inject", nwin, 16);
    chk("n_done_inject", ndone, 1);
    chk("err_busy_start", cfg_err, 1);
    ch_off = 37;
    run_frame(0, 0, 320, 4, 30, 90, -1, 0, nwin, ndone);
    chk("n_win_320x4", nwin, 1280);
    chk("n_done_320x4", ndone, 1);
    chk("err_cleared", cfg_err, 0);
    ch_off = 0;
    run_frame(0, 0, 4, 4, 100, 100, -1, 1, nwin, ndone);
    for (int i = 0; i < 6; i++) begin
      if (frame_done) ndone++;
      @(posedge clk);
      #1;
    end
    chk("n_done_abort", ndone, 0);
    chk("busy_abort", busy, 0);
    chk("valid_abort", out_valid, 0);
    run_frame(0, 0, 4, 4, 100, 100, -1, 0, nwin, ndone);
    chk("n_win_after_abort", nwin, 16);
    chk("n_done_after_abort", ndone, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter CH_NUM, default 18, meaning channels carried per pixel beat.
REQ-002 Parameter DATA_WIDTH, default 8, meaning bits per channel sample.
REQ-003 Parameter MAX_WIDTH, default 320, meaning maximum image width and line-buffer depth.
REQ-004 Parameter DIM_WIDTH, default 9, meaning bit width of the runtime width/height fields.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cfg_start  input  1  one-cycle pulse; latches cfg_* and begins a frame.
REQ-008 cfg_mode  input  1  0 = 3x3 window, 1 = pointwise (1x1).
REQ-009 cfg_stride2  input  1  1 = emit only even-row/even-column centres.
REQ-010 cfg_width, cfg_height  input  DIM_WIDTH each  image size in pixels.
REQ-011 in_data  input  CH_NUM*DATA_WIDTH  one pixel, all channels; channel ch at bits [ch*DATA_WIDTH +: DATA_WIDTH].
REQ-012 in_valid / in_ready  input / output  1 each  pixel handshake; transfer when both are high.
REQ-013 out_window  output  9*CH_NUM*DATA_WIDTH  tap t = 3*dy+dx (top-left first), channel ch at [(t*CH_NUM+ch)*DATA_WIDTH +: DATA_WIDTH].
REQ-014 out_valid / out_ready  output / input  1 each  window handshake.
REQ-015 busy  output  1  high from accepted cfg_start until frame_done.
REQ-016 frame_done  output  1  one-cycle pulse after the last window of a frame transfers.
REQ-017 cfg_err  output  1  sticky; set when a rejected config is received, cleared by the next accepted cfg_start.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, FLUSH, DONE; IDLE->RUN on valid cfg_start; RUN->FLUSH after W*H pixels are accepted (3x3 mode) or RUN->DONE (PW mode); FLUSH->DONE after W+1 virtual pixels; DONE->IDLE after the final output transfer, pulsing frame_done.
REQ-019 Config SHALL be rejected (stay IDLE, set cfg_err) when width < 2, width > MAX_WIDTH, height < 2, or cfg_start arrives while busy; a cfg_start while busy SHALL NOT disturb the running frame.
REQ-020 Column and row counters SHALL wrap column W-1 -> 0 with row increment; the row counter stops at H-1.
REQ-021 3x3 mode SHALL use "same" zero padding: the window centred on (r,c) is formed when input (r+1,c+1) is accepted, or when the equivalent virtual pixel is generated in FLUSH; taps outside the image SHALL read 0.
REQ-022 FLUSH SHALL generate W+1 virtual zero pixels internally, one per cycle when not stalled, without asserting in_ready.
REQ-023 PW mode SHALL place the pixel in tap 4 and zero all other taps, with no row lag.
REQ-024 With cfg_stride2=1, a window SHALL be emitted only for even r and even c; the other positions still advance the counters and line buffers.
REQ-025 out_window/out_valid SHALL be registered: latency is 1 cycle from the triggering accept (or virtual pixel) to out_valid.
REQ-026 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready); a window SHALL be held stable while out_valid && !out_ready.
REQ-027 Total windows per frame SHALL be W*H (stride 1) or ceil(W/2)*ceil(H/2) (stride 2).

Reset
REQ-028 On rst, the FSM SHALL go to IDLE, counters SHALL clear, and out_valid, in_ready, busy, frame_done and cfg_err SHALL be 0; out_window SHALL be 0.
REQ-029 rst mid-frame SHALL abandon the frame with no frame_done; line-buffer RAM contents need not clear because padding masks stale data.

Structure
REQ-030 Package conv_pkg SHALL hold the mode encoding, the FSM state encoding, and the constants TAP_NUM=9 and CENTRE_TAP=4.
REQ-031 One sub-module, conv_line_buffer, SHALL hold two row delay lines of depth MAX_WIDTH (simple dual-port RAM, CH_NUM*DATA_WIDTH wide) with a shared write/read pointer that wraps at runtime width W.
REQ-032 The 3x3 shift-register window and the padding mask SHALL reside in conv_window_gen.

Verification
REQ-033 4x4 frame, 3x3 mode, stride 1, pixel value = 16r+c (all channels) -> 16 windows; window (0,0) taps = {0,0,0,0,0x00,0x01,0,0x10,0x11}; frame_done once.
REQ-034 The same frame with stride 2 -> exactly 4 windows, centred (0,0),(0,2),(2,0),(2,2).
REQ-035 PW mode, W=3, H=2 -> 6 windows, each 1 cycle after its accept, tap 4 = pixel, taps 0-3 and 5-8 = 0.
REQ-036 Random out_ready at 30% duty on a 320x4 frame -> no window lost, duplicated, or changed while stalled; the window count equals 1280.
REQ-037 cfg_width=1, then cfg_start while busy -> cfg_err=1, the first case stays IDLE, and the running frame completes unchanged.
REQ-038 rst asserted for one cycle during FLUSH, then a new 4x4 frame -> correct windows and no frame_done from the aborted frame.
